clk_div_multi: RTL and testbench
================================

# clk_div_multi

Multi-channel programmable clock divider, the parametrised successor to the single fixed divider. Each of CH_NUM channels divides clk_in by a runtime-loadable even ratio. Each channel produces a 50%-duty divided clock plus a one-cycle tick strobe for use as a clock enable. It sits at the top of each lab design, feeding slow enables to display, debounce and FSM blocks.

## Interface
- CNT_W, 27: counter and divisor width per channel.
- CH_NUM, 2: number of independent channels.
- DIV_INIT, 2**(CNT_W-1): reset divisor for every channel. Default gives an output period of 2^CNT_W cycles.
- clk_in  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  global run enable; low freezes all counters and outputs.
- load  input  1  one-cycle strobe that captures div_val.
- div_val  input  CH_NUM*CNT_W  channel i divisor at bits [i*CNT_W +: CNT_W].
- clk_out  output  CH_NUM  divided clocks (registered).
- tick  output  CH_NUM  one-cycle pulse coincident with each 0->1 of clk_out[i] (registered).
- sync  input  1  present only with CLK_DIV_SYNC_EN; see Configuration.

## Operation
- Per channel state:
  - cnt[CNT_W], counts 0..D-1.
  - act[CNT_W], the active divisor D.
  - shd[CNT_W], the shadow divisor.
  - clk_out, tick.
- D >= 1: half-period is D cycles; clk_out period is 2*D cycles. D=1 gives clk_in/2.
- D == 0: channel off. cnt held 0, clk_out held 0, tick held 0.
- When en=1 and D != 0:
  - If cnt == D-1 (wrap): cnt <= 0 and clk_out toggles. On the same edge act <= shd (glitch-free reload at half-period boundary only). tick <= 1 iff clk_out goes 0->1.
  - Otherwise: cnt <= cnt+1 and tick <= 0.
- en=0: cnt, clk_out and act hold. tick <= 0. load still writes shd.
- load=1: shd <= div_val slice for every channel.
- load and wrap on the same edge: act takes the old shd. The new value takes effect at the following wrap.
- Channel off (act==0) and load=1: act and shd both take div_val on that edge, so an off channel starts immediately.
- Reload to D=0 at a wrap: cnt <= 0 and clk_out <= 0 on that edge, overriding the toggle. tick <= 0.
- Counter arithmetic is unsigned CNT_W-bit. cnt never exceeds act-1, so no overflow is possible.
- Channels are fully independent except for the shared en, load and sync.

## Timing
- Reset values:
  - cnt = 0, clk_out = 0, tick = 0.
  - act = shd = DIV_INIT.
- Reset takes priority over en, load and sync.
- Reset asserted mid-operation aborts on the next edge. There is no partial-period output.
- After rst falls with D active and en=1, clk_out[i] rises at the D-th rising edge of clk_in. tick[i] is high for exactly that cycle.
- Steady state:
  - clk_out high for D cycles, then low for D cycles.
  - tick high 1 cycle in every 2*D cycles.
- Latency from load to new ratio: at most D_old cycles, i.e. the next wrap. For an off channel it is 0 extra cycles: counting starts on the edge after load.
- en deassert/reassert: the phase resumes exactly where frozen. No cycle is lost or added.

## Configuration
- CLK_DIV_SYNC_EN defined:
  - Adds input sync, 1 bit.
  - sync=1 on an edge forces, for all channels: cnt <= 0, clk_out <= 0, tick <= 0, act <= shd. All channels become phase-aligned.
  - sync overrides en and wrap. If sync and load coincide, act takes the old shd.
- Undefined: the sync port and its logic are absent. Channels align only via rst.

## Test plan
- Reset and default (CNT_W=4, CH_NUM=2, DIV_INIT=8):
  - Stimulus: rst high 2 cycles, then low with en=1.
  - Required: both clk_out rise at edge 8 after release. Period 16. tick high 1 cycle every 16.
- Runtime load (D=3 -> 5):
  - Stimulus: load div_val ch0=5 mid-half-period.
  - Required: remaining half-period stays 3 cycles; following half-periods are 5 cycles. Load coinciding with a wrap delays the change by one half-period.
- Off channel:
  - Stimulus: load ch1=0, then later ch1=2.
  - Required: ch1 output goes low at its next wrap and stays low with no ticks. After loading 2, it counts from the next edge and first rises 2 cycles later.
- en freeze:
  - Stimulus: D=4, drop en for 7 cycles mid-half-period.
  - Required: clk_out and cnt hold; tick stays 0. After resume, the remaining count completes exactly.
- D=1 (clk_in/2):
  - Required: clk_out toggles every cycle. tick on every other cycle.
- With CLK_DIV_SYNC_EN:
  - Stimulus: ch0 at D=3 and ch1 at D=6, free-running; pulse sync.
  - Required: both clk_out low on the next edge. ch0 rises 3 cycles later; ch1 rises 6 cycles later.

Source files
------------

// File: rtl/clk_div_multi.sv
// CH_NUM independent even-ratio clock dividers with shadowed divisors reloaded at half-period wraps.
// Registered clk_out/tick; optional sync input (CLK_DIV_SYNC_EN) phase-aligns all channels.
module clk_div_multi #(
  parameter int          CNT_W    = 27,
  parameter int          CH_NUM   = 2,
  parameter int unsigned DIV_INIT = 2**(CNT_W-1)
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [CH_NUM*CNT_W-1:0] div_val,
`ifdef CLK_DIV_SYNC_EN
  input  logic                    sync,
`endif
  output logic [CH_NUM-1:0]       clk_out,
  output logic [CH_NUM-1:0]       tick
);

  logic sync_i;
`ifdef CLK_DIV_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] shd;
    logic [CNT_W-1:0] din;
    logic             co;
    logic             tk;
    logic             wrap;

    assign din        = div_val[i*CNT_W +: CNT_W];
    assign wrap       = (cnt == act - CNT_W'(1));
    assign clk_out[i] = co;
    assign tick[i]    = tk;

    always_ff @(posedge clk_in) begin
      if (rst) begin
        cnt <= '0;
        co  <= 1'b0;
        tk  <= 1'b0;
        act <= CNT_W'(DIV_INIT);
        shd <= CNT_W'(DIV_INIT);
      end else if (sync_i) begin
        cnt <= '0;
        co  <= 1'b0;
        tk  <= 1'b0;
        act <= shd;
        if (load) shd <= din;
      end else if (act == '0) begin
        // An off channel takes a new divisor straight into act so it starts without waiting for a wrap.
        cnt <= '0;
        co  <= 1'b0;
        tk  <= 1'b0;
        if (load) begin
          act <= din;
          shd <= din;
        end
      end else if (en) begin
        if (wrap) begin
          cnt <= '0;
          act <= shd;
          if (shd == '0) begin
            co <= 1'b0;
            tk <= 1'b0;
          end else begin
            co <= ~co;
            tk <= ~co;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
          tk  <= 1'b0;
        end
        if (load) shd <= din;
      end else begin
        tk <= 1'b0;
        if (load) shd <= din;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a half-period countdown model predicts clk_out/tick per edge.
module tb_clk_div_multi;
  localparam int CW = 4;
  localparam int CN = 2;
  localparam int DI = 8;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic          sync = 1'b0;
  logic [CN*CW-1:0] div_val = '0;
  logic [CN-1:0] clk_out;
  logic [CN-1:0] tick;

  clk_div_multi #(.CNT_W(CW), .CH_NUM(CN), .DIV_INIT(DI)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (en),
    .load   (load),
    .div_val(div_val),
`ifdef CLK_DIV_SYNC_EN
    .sync   (sync),
`endif
    .clk_out(clk_out),
    .tick   (tick)
  );

  always #5 clk_in = ~clk_in;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [2*CN-1:0] exp_q[$];

  // Model state: active/shadow divisor, cycles left until the next toggle, output level, tick.
  int m_act[CN];
  int m_shd[CN];
  int m_rem[CN];
  bit m_lvl[CN];
  bit m_tck[CN];
  int cur0 = 0;
  int cur1 = 0;

  task automatic step(input bit r, input bit e, input bit l, input bit s, input int d0, input int d1);
    int  dv[CN];
    bit  sy;
    int  old_shd;
    logic [2*CN-1:0] ex;
    dv[0] = d0 & 15;
    dv[1] = d1 & 15;
`ifdef CLK_DIV_SYNC_EN
    sy = s;
`else
    sy = 1'b0;
`endif
    rst = r; en = e; load = l; sync = s;
    div_val = {4'(dv[1]), 4'(dv[0])};
    for (int i = 0; i < CN; i++) begin
      old_shd = m_shd[i];
      if (r) begin
        m_act[i] = DI; m_shd[i] = DI; m_rem[i] = DI; m_lvl[i] = 0; m_tck[i] = 0;
      end else if (sy) begin
        m_act[i] = old_shd; m_rem[i] = old_shd; m_lvl[i] = 0; m_tck[i] = 0;
        if (l) m_shd[i] = dv[i];
      end else if (m_act[i] == 0) begin
        m_lvl[i] = 0; m_tck[i] = 0;
        if (l) begin m_act[i] = dv[i]; m_shd[i] = dv[i]; m_rem[i] = dv[i]; end
      end else if (e) begin
        m_rem[i] = m_rem[i] - 1;
        m_tck[i] = 0;
        if (m_rem[i] == 0) begin
          m_act[i] = old_shd;
          m_rem[i] = old_shd;
          if (old_shd == 0) m_lvl[i] = 0;
          else begin
            m_lvl[i] = !m_lvl[i];
            m_tck[i] = m_lvl[i];
          end
        end
        if (l) m_shd[i] = dv[i];
      end else begin
        m_tck[i] = 0;
        if (l) m_shd[i] = dv[i];
      end
    end
    ex = {m_tck[1], m_tck[0], m_lvl[1], m_lvl[0]};
    exp_q.push_back(ex);
    @(posedge clk_in);
    #2;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, cur0, cur1);
  endtask

  task automatic ld(input int a, input int b);
    cur0 = a; cur1 = b;
    step(0, 1, 1, 0, a, b);
  endtask

  initial begin : monitor
    logic [2*CN-1:0] e;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared++;
        if ({tick, clk_out} !== e) begin
          mismatched++;
          $display("FAIL outputs cyc%0d: tick=%b clk_out=%b, expected tick=%b clk_out=%b",
                   cyc, tick, clk_out, e[3:2], e[1:0]);
        end
      end
    end
  end

  initial begin : stim
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    run(40);
    ld(3, 3);
    run(20);
    ld(5, 3);
    run(30);
    ld(5, 0);
    run(20);
    ld(5, 2);
    run(20);
    ld(4, 4);
    run(10);
    for (int k = 0; k < 7; k++) step(0, 0, 0, 0, cur0, cur1);
    run(20);
    ld(1, 1);
    run(12);
    ld(3, 6);
    run(17);
    step(0, 1, 0, 1, cur0, cur1);
    run(20);
    for (int k = 0; k < 500; k++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 49) == 0,
           int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
    end
    run(30);
    @(negedge clk_in);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
